// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and index-width helper.
package rst_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        StHold,
        StWait,
        StRun,
        StSoft
    } state_e;

    // Index width for a domain count; a single domain still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rst_seq_rr_arb
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned NumDomains = 4,
    parameter int unsigned IdxW       = idx_width(NumDomains)
) (
    input  logic [NumDomains-1:0] req_i,
    input  logic [IdxW-1:0]       ptr_i,
    output logic                  valid_o,
    output logic [NumDomains-1:0] gnt_o,
    output logic [IdxW-1:0]       idx_o
);

    always_comb begin
        int unsigned j;
        j       = 0;
        valid_o = 1'b0;
        gnt_o   = '0;
        idx_o   = '0;
        for (int unsigned i = 0; i < NumDomains; i++) begin
            j = (32'(ptr_i) + i) % NumDomains;
            if (!valid_o && req_i[IdxW'(j)]) begin
                valid_o            = 1'b1;
                gnt_o[IdxW'(j)]    = 1'b1;
                idx_o              = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: hold all domains, release them in order with per-domain delays,
// then serve soft-reset requests one domain at a time via round-robin grant.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned NumDomains      = 4,
    parameter int unsigned CntWidth        = 8,
    parameter int unsigned MinAssertCycles = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumDomains*CntWidth-1:0] delay_i,
    input  logic [NumDomains-1:0]          req_i,
    output logic [NumDomains-1:0]          gnt_o,
    output logic [NumDomains-1:0]          rst_domain_o,
    output logic                           seq_done_o,
    output logic                           busy_o
);

    localparam int unsigned IdxW  = idx_width(NumDomains);
    localparam int unsigned HoldW = $clog2(MinAssertCycles + 1);
    localparam int unsigned CW    = (CntWidth > HoldW) ? CntWidth : HoldW;
    localparam logic [CW-1:0]   HoldLast = CW'(MinAssertCycles - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumDomains - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [IdxW-1:0]         ptr_q, ptr_d;
    logic [NumDomains-1:0]   rst_dom_q, rst_dom_d;

    logic                    arb_valid;
    logic [NumDomains-1:0]   arb_gnt;
    logic [IdxW-1:0]         arb_idx;
    logic [CntWidth-1:0]     dly [NumDomains];

    always_comb begin
        for (int unsigned k = 0; k < NumDomains; k++) begin
            dly[k] = delay_i[k*CntWidth +: CntWidth];
        end
    end

    rst_seq_rr_arb #(
        .NumDomains (NumDomains),
        .IdxW       (IdxW)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StHold;
            cnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            rst_dom_q <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            rst_dom_q <= rst_dom_d;
        end
    end

    // idx_q names the domain being released in WAIT and the one being reset in SOFT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        rst_dom_d = rst_dom_q;
        case (state_q)
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StWait;
                    idx_d   = '0;
                    cnt_d   = CW'(dly[0]);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rst_dom_d[idx_q] = 1'b0;
                    if (idx_q == LastIdx) begin
                        state_d = StRun;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                        cnt_d = CW'(dly[idx_q + IdxW'(1)]);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StRun: begin
                if (arb_valid) begin
                    state_d            = StSoft;
                    rst_dom_d[arb_idx] = 1'b1;
                    idx_d              = arb_idx;
                    cnt_d              = '0;
                    ptr_d              = (arb_idx == LastIdx) ? '0 : arb_idx + IdxW'(1);
                end
            end
            StSoft: begin
                if (cnt_q == HoldLast) begin
                    rst_dom_d[idx_q] = 1'b0;
                    state_d          = StRun;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_comb begin
        gnt_o        = (state_q == StRun) ? arb_gnt : '0;
        rst_domain_o = rst_dom_q;
        seq_done_o   = (state_q == StRun) || (state_q == StSoft);
        busy_o       = (state_q != StRun);
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: release timing, soft-reset arbitration and reset recovery.
module tb_rst_seq_ctrl;

    logic        clk;
    logic        rst_i;
    logic [31:0] delay_i;
    logic [3:0]  req_i;
    logic [3:0]  gnt_o;
    logic [3:0]  rst_domain_o;
    logic        seq_done_o;
    logic        busy_o;

    int checks;
    int failures;
    int cyc;
    int rel [4];
    int done_cyc;
    int busy0_cyc;

    rst_seq_ctrl #(
        .NumDomains      (4),
        .CntWidth        (8),
        .MinAssertCycles (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .delay_i      (delay_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .rst_domain_o (rst_domain_o),
        .seq_done_o   (seq_done_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1ns after an edge; outputs are sampled on the following negedge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_record(input int ncyc, input int chg_cyc, input logic [31:0] chg_val);
        for (int k = 0; k < 4; k++) rel[k] = -1;
        done_cyc  = -1;
        busy0_cyc = -1;
        for (int n = 0; n < ncyc; n++) begin
            step();
            if (cyc == chg_cyc) delay_i = chg_val;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rel[k] < 0 && !rst_domain_o[k]) rel[k] = cyc;
            end
            if (done_cyc < 0 && seq_done_o) done_cyc = cyc;
            if (busy0_cyc < 0 && !busy_o) busy0_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        req_i   = 4'b0000;
        delay_i = '0;
        do_reset();
        @(negedge clk);
        checks += 4;
        if (rst_domain_o !== 4'hF) begin
            failures++;
            $display("FAIL reset_rst_domain: got %b, expected 1111", rst_domain_o);
        end
        if (gnt_o !== 4'h0) begin
            failures++;
            $display("FAIL reset_gnt: got %b, expected 0000", gnt_o);
        end
        if (seq_done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_seq_done: got %b, expected 0", seq_done_o);
        end
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy: got %b, expected 1", busy_o);
        end
    endtask

    task automatic test_release();
        int exp_rel [4];
        exp_rel = '{5, 8, 14, 16};
        req_i   = 4'b0000;
        delay_i = {8'd1, 8'd5, 8'd2, 8'd0};
        do_reset();
        run_record(22, -1, '0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rel[k] !== exp_rel[k]) begin
                failures++;
                $display("FAIL release_dom%0d: got cycle %0d, expected %0d", k, rel[k], exp_rel[k]);
            end
        end
        checks += 2;
        if (done_cyc !== 16) begin
            failures++;
            $display("FAIL release_seq_done: got cycle %0d, expected 16", done_cyc);
        end
        if (busy0_cyc !== 16) begin
            failures++;
            $display("FAIL release_busy_low: got cycle %0d, expected 16", busy0_cyc);
        end
    endtask

    task automatic test_zero_delays();
        int exp_rel [4];
        exp_rel = '{5, 6, 7, 8};
        req_i   = 4'b0000;
        delay_i = '0;
        do_reset();
        run_record(12, -1, '0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rel[k] !== exp_rel[k]) begin
                failures++;
                $display("FAIL zero_dom%0d: got cycle %0d, expected %0d", k, rel[k], exp_rel[k]);
            end
        end
        checks++;
        if (done_cyc !== 8) begin
            failures++;
            $display("FAIL zero_seq_done: got cycle %0d, expected 8", done_cyc);
        end
    endtask

    task automatic test_early_req();
        int         first_gnt;
        logic [3:0] gv;
        int         ngnt;
        int         dom2;
        int         busy_n;
        int         other;
        first_gnt = -1;
        gv        = 4'h0;
        ngnt      = 0;
        dom2      = 0;
        busy_n    = 0;
        other     = 0;
        req_i     = 4'b0000;
        delay_i   = '0;
        do_reset();
        for (int n = 0; n < 25; n++) begin
            step();
            if (cyc == 2) req_i = 4'b0100;
            if (first_gnt >= 0 && cyc == first_gnt + 1) req_i = 4'b0000;
            @(negedge clk);
            if (gnt_o != 4'h0) begin
                ngnt++;
                if (first_gnt < 0) begin
                    first_gnt = cyc;
                    gv        = gnt_o;
                end
            end
            if (cyc > 8) begin
                if (rst_domain_o[2]) dom2++;
                if (busy_o) busy_n++;
                if ((rst_domain_o & 4'b1011) != 4'h0) other++;
            end
        end
        checks += 6;
        if (first_gnt !== 8) begin
            failures++;
            $display("FAIL early_first_gnt: got cycle %0d, expected 8", first_gnt);
        end
        if (gv !== 4'b0100) begin
            failures++;
            $display("FAIL early_gnt_value: got %b, expected 0100", gv);
        end
        if (ngnt !== 1) begin
            failures++;
            $display("FAIL early_gnt_pulses: got %0d, expected 1", ngnt);
        end
        if (dom2 !== 4) begin
            failures++;
            $display("FAIL early_soft_len: got %0d cycles, expected 4", dom2);
        end
        if (busy_n !== 4) begin
            failures++;
            $display("FAIL early_busy_len: got %0d cycles, expected 4", busy_n);
        end
        if (other !== 0) begin
            failures++;
            $display("FAIL early_other_domains: got %0d disturbed cycles, expected 0", other);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gseq [4];
        int         gcyc [4];
        logic [3:0] exp_g [4];
        int         exp_c [4];
        int         ng;
        exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        exp_c = '{8, 13, 18, 23};
        for (int k = 0; k < 4; k++) begin
            gseq[k] = 4'h0;
            gcyc[k] = -1;
        end
        ng      = 0;
        req_i   = 4'b0000;
        delay_i = '0;
        do_reset();
        req_i = 4'b1011;
        for (int n = 0; n < 30; n++) begin
            step();
            if (ng > 0 && cyc == gcyc[ng-1] + 1) begin
                req_i = req_i & ~gseq[ng-1];
                if (ng == 3) req_i = req_i | 4'b0001;
            end
            @(negedge clk);
            if (gnt_o != 4'h0 && ng < 4) begin
                gseq[ng] = gnt_o;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        checks++;
        if (ng !== 4) begin
            failures++;
            $display("FAIL rr_grant_count: got %0d, expected 4", ng);
        end
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (gseq[k] !== exp_g[k]) begin
                failures++;
                $display("FAIL rr_gnt%0d_value: got %b, expected %b", k, gseq[k], exp_g[k]);
            end
            if (gcyc[k] !== exp_c[k]) begin
                failures++;
                $display("FAIL rr_gnt%0d_cycle: got %0d, expected %0d", k, gcyc[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_reset_mid_soft();
        int         first_gnt;
        logic [3:0] gv;
        logic [3:0] dom_at4;
        logic [3:0] dom_at8;
        logic       done_at8;
        first_gnt = -1;
        gv        = 4'h0;
        dom_at4   = 4'h0;
        dom_at8   = 4'hF;
        done_at8  = 1'b0;
        req_i     = 4'b0000;
        delay_i   = '0;
        do_reset();
        req_i = 4'b0100;
        while (cyc < 10) begin
            step();
            if (cyc == 9) req_i = 4'b0000;
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        cyc   = 0;
        @(negedge clk);
        checks += 4;
        if (rst_domain_o !== 4'hF) begin
            failures++;
            $display("FAIL midsoft_rst_domain: got %b, expected 1111", rst_domain_o);
        end
        if (seq_done_o !== 1'b0) begin
            failures++;
            $display("FAIL midsoft_seq_done: got %b, expected 0", seq_done_o);
        end
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL midsoft_busy: got %b, expected 1", busy_o);
        end
        if (gnt_o !== 4'h0) begin
            failures++;
            $display("FAIL midsoft_gnt: got %b, expected 0000", gnt_o);
        end
        // Pointer must be back at 0, so domain 1 wins over domain 3.
        req_i = 4'b1010;
        for (int n = 0; n < 8; n++) begin
            step();
            @(negedge clk);
            if (cyc == 4) dom_at4 = rst_domain_o;
            if (cyc == 8) begin
                dom_at8  = rst_domain_o;
                done_at8 = seq_done_o;
            end
            if (gnt_o != 4'h0 && first_gnt < 0) begin
                first_gnt = cyc;
                gv        = gnt_o;
            end
        end
        step();
        req_i = 4'b0000;
        checks += 5;
        if (dom_at4 !== 4'hF) begin
            failures++;
            $display("FAIL midsoft_restart_hold: got %b, expected 1111", dom_at4);
        end
        if (dom_at8 !== 4'h0) begin
            failures++;
            $display("FAIL midsoft_restart_release: got %b, expected 0000", dom_at8);
        end
        if (done_at8 !== 1'b1) begin
            failures++;
            $display("FAIL midsoft_restart_done: got %b, expected 1", done_at8);
        end
        if (first_gnt !== 8) begin
            failures++;
            $display("FAIL midsoft_gnt_cycle: got %0d, expected 8", first_gnt);
        end
        if (gv !== 4'b0010) begin
            failures++;
            $display("FAIL midsoft_gnt_value: got %b, expected 0010", gv);
        end
    endtask

    task automatic test_delay_sampling();
        int exp_rel [4];
        exp_rel = '{5, 8, 12, 14};
        req_i   = 4'b0000;
        delay_i = {8'd1, 8'd5, 8'd2, 8'd0};
        do_reset();
        // Field 1 changes 2->9 while in WAIT(1); field 2 changes 5->3 before WAIT(2).
        run_record(20, 6, {8'd1, 8'd3, 8'd9, 8'd0});
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rel[k] !== exp_rel[k]) begin
                failures++;
                $display("FAIL sample_dom%0d: got cycle %0d, expected %0d", k, rel[k], exp_rel[k]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_i    = 1'b1;
        req_i    = 4'b0000;
        delay_i  = '0;
        test_reset();
        test_release();
        test_zero_delays();
        test_early_req();
        test_round_robin();
        test_reset_mid_soft();
        test_delay_sampling();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Synthesizable reset sequencer for multi-domain designs.
- On leaving global reset, holds every domain reset for a minimum time, then releases the domains one by one in index order, each after its own programmable delay.
- After the sequence completes, it serves per-domain soft-reset requests through a round-robin req/gnt handshake, one domain at a time.
- Sits between the global reset and every subsystem's reset input.

Parameters:
- NumDomains, 4, number of reset domains (>=1).
- CntWidth, 8, width of each per-domain release-delay field.
- MinAssertCycles, 4, cycles a domain reset is held in HOLD and in a soft reset (>=1).

Ports:
- clk_i  input  1  single clock; all logic on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- delay_i  input  NumDomains*CntWidth  release delay per domain; field k is bits [k*CntWidth +: CntWidth].
- req_i  input  NumDomains  soft-reset request per domain; level, held until granted.
- gnt_o  output  NumDomains  one-hot, one-cycle grant pulse.
- rst_domain_o  output  NumDomains  per-domain reset, active-high.
- seq_done_o  output  1  initial release sequence finished.
- busy_o  output  1  sequencing or soft reset in progress.

Behaviour:
- Reset values (while rst_i=1): rst_domain_o all 1, gnt_o 0, seq_done_o 0, busy_o 1, FSM in HOLD, counter 0, round-robin pointer 0.
- Interface: one clock clk_i; reset rst_i is synchronous, active-high.
- Cycle numbering: cycle n is the state after the n-th rising edge that samples rst_i=0, counting from 1.
- FSM states: HOLD -> WAIT(k), k=0..NumDomains-1 -> RUN <-> SOFT.
- HOLD:
  - Lasts MinAssertCycles cycles.
  - Then enters WAIT(0) and loads the counter with delay_i field 0.
- WAIT(k):
  - The delay field is sampled only on entry.
  - The counter decrements each cycle.
  - At counter==0, rst_domain_o[k] clears on the next edge and the FSM enters WAIT(k+1), loading field k+1.
  - From WAIT(NumDomains-1) the FSM enters RUN instead.
  - Domain k therefore releases at cycle MinAssertCycles + sum over j<=k of (delay_j + 1).
  - A delay of 0 gives release one cycle after entry.
- seq_done_o and busy_o:
  - seq_done_o goes 1 in the same cycle the last domain releases and stays 1 until rst_i.
  - busy_o goes 0 in that same cycle.
- req_i during HOLD or WAIT is ignored; no grant is issued, and the request stays pending.
- RUN:
  - If any req_i bit is set, gnt_o[g]=1 combinationally in that cycle.
  - g is the first set bit at or after the pointer, wrapping modulo NumDomains.
  - On that edge, rst_domain_o[g] is set, the pointer becomes (g+1) mod NumDomains, and the FSM enters SOFT.
- SOFT:
  - rst_domain_o[g] is held 1 for exactly MinAssertCycles cycles, then cleared, and the FSM returns to RUN.
  - busy_o=1 and gnt_o=0 throughout.
  - Other requests wait; the earliest next grant is the first RUN cycle.
- Requester side: the requester must drop req_i[g] in the cycle after gnt_o[g]. A still-high req_i[g] in RUN is treated as a new request.
- rst_i mid-operation: at the next edge all state returns to reset values, including during SOFT or WAIT.
- Only one domain is in soft reset at a time. Domains other than g are untouched during SOFT.

Decomposition:
- Package rst_seq_ctrl_pkg:
  - State enum: HOLD, WAIT, RUN, SOFT.
  - Index type: logic [$clog2(NumDomains)-1:0], or 1 bit when NumDomains=1.
- One sub-module, rst_seq_rr_arb: combinational round-robin pick.
  - Inputs: req, pointer.
  - Outputs: valid, one-hot gnt, index.
  - The pointer register lives in the parent.

Test Plan:
- Defaults used throughout: NumDomains=4, MinAssertCycles=4.
- Release timing: delays {0,2,5,1}, drop rst_i -> rst_domain_o[0..3] release at cycles 5, 8, 14, 16; seq_done_o and busy_o=0 at cycle 16.
- All-zero delays -> domains release at cycles 5, 6, 7, 8.
- Early request ignored: req_i=4'b0100 asserted at cycle 2 -> no gnt before cycle 8. Then gnt_o=4'b0100 for one cycle, rst_domain_o[2]=1 for exactly 4 cycles, busy_o=1 for those 4 cycles.
- Round-robin ordering: in RUN with pointer 0, hold req_i=4'b1011 and drop each bit after its grant -> grants in order 0, 1, 3, with 4 SOFT cycles between grants. A re-asserted req_i[0] is granted after 3.
- Reset mid-SOFT: rst_i=1 for one cycle during SOFT -> next edge all rst_domain_o=1, seq_done_o=0, pointer 0. Full sequence restarts when rst_i falls.
- Delay sampling: change delay_i field 1 from 2 to 9 while in WAIT(1) -> domain 1 still releases using 2. Field 2 uses the new value if it changed before WAIT(2) entry.
